// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm scheduler: state encodings, CPU register
// map, CTRL bit positions and a BCD-to-binary helper.
package alarm_ctrl_pkg;

  // State encodings are visible to the CPU through STATUS[1:0].
  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } state_t;

  // CPU register window.
  localparam logic [1:0] ADDR_ALARM_H = 2'd0;
  localparam logic [1:0] ADDR_ALARM_M = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // CTRL write bits: enable is stored, snooze/stop are one-shot commands.
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_SNOOZE_BIT = 1;
  localparam int CTRL_STOP_BIT   = 2;

  // Largest legal alarm values; writes above these are dropped.
  localparam logic [5:0] MAX_HOUR = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  // Two BCD digits to binary (tens*10 + ones).
  function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return 6'(tens) * 6'd10 + 6'(ones);
  endfunction

endpackage

// File: rtl/alarm_prescaler.sv
// Ring-duration timer: a clock prescaler feeding a seconds counter. Both
// counters clear on clr, advance only while en is high, and hold otherwise.
module alarm_prescaler #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int RING_SEC    = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int SW = $clog2(RING_SEC + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [SW-1:0] SEC_LAST = SW'(RING_SEC - 1);
  localparam logic [SW-1:0] SEC_ONE  = SW'(1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic          pre_wrap;

  assign pre_wrap = (pre_cnt_q == PRE_LAST);

  // done marks the cycle whose edge makes sec_cnt reach RING_SEC, so the
  // caller leaves RINGING on exactly that edge rather than one cycle late.
  assign done = en && pre_wrap && (sec_cnt_q == SEC_LAST);

  // Next-count logic: clear wins, otherwise count only when enabled.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    sec_cnt_d = sec_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
      sec_cnt_d = '0;
    end else if (en) begin
      if (pre_wrap) begin
        pre_cnt_d = '0;
        sec_cnt_d = sec_cnt_q + SEC_ONE;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_ONE;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      sec_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm scheduler beside the time-of-day timer. Compares the BCD time with a
// CPU-programmed alarm and sequences DISABLED/ARMED/RINGING/SNOOZE, driving
// ring while RINGING. CPU access is a 4-register window.
module alarm_ctrl #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour1,
  input  logic [3:0] hour0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  input  logic       sel,
  input  logic [1:0] address,
  input  logic       write_en,
  input  logic [5:0] data_in,
  output logic [5:0] data_out,
  output logic       ring
);

  import alarm_ctrl_pkg::*;

  localparam int NW = $clog2(SNOOZE_MIN + 1);
  localparam logic [NW-1:0] SNZ_LOAD = NW'(SNOOZE_MIN);
  localparam logic [NW-1:0] SNZ_ONE  = NW'(1);

  logic [4:0]    alarm_h_q, alarm_h_d;
  logic [5:0]    alarm_m_q, alarm_m_d;
  logic          enable_q, enable_d;
  state_t        state_q, state_d;
  logic [NW-1:0] snz_cnt_q, snz_cnt_d;
  logic          match_q;
  logic [3:0]    min0_q;
  logic          valid_q;

  logic [5:0] hour_bin, min_bin;
  logic       match, fire, min_tick;
  logic       reg_wr, ctrl_wr, snooze_cmd, stop_cmd;
  logic       ringing, ring_start, ring_done;

  // Binary view of the displayed time. Compared at 6 bits so that the
  // 5-bit alarm hour needs no truncation of the converted value.
  assign hour_bin = bcd_to_bin({2'b00, hour1}, hour0);
  assign min_bin  = bcd_to_bin({1'b0, min1}, min0);

  assign match    = (hour_bin == {1'b0, alarm_h_q}) && (min_bin == alarm_m_q);
  // Only the rising edge of match rings, so enabling mid-minute stays quiet.
  assign fire     = valid_q && match && !match_q;
  assign min_tick = valid_q && (min0 != min0_q);

  // Commands act in the same cycle they are written.
  assign reg_wr     = sel && write_en;
  assign ctrl_wr    = reg_wr && (address == ADDR_CTRL);
  assign snooze_cmd = ctrl_wr && data_in[CTRL_SNOOZE_BIT];
  assign stop_cmd   = ctrl_wr && data_in[CTRL_STOP_BIT];

  assign ringing    = (state_q == ST_RINGING);
  assign ring_start = (state_d == ST_RINGING) && !ringing;
  assign ring       = ringing;

  // CPU register writes; out-of-range alarm values leave the register alone.
  always_comb begin
    alarm_h_d = alarm_h_q;
    alarm_m_d = alarm_m_q;
    enable_d  = enable_q;
    if (reg_wr) begin
      case (address)
        ADDR_ALARM_H: if (data_in <= MAX_HOUR) alarm_h_d = data_in[4:0];
        ADDR_ALARM_M: if (data_in <= MAX_MIN)  alarm_m_d = data_in;
        ADDR_CTRL:    enable_d = data_in[CTRL_ENABLE_BIT];
        default:      ;
      endcase
    end
  end

  // Next state: disable overrides all, then stop > snooze > timeout > fire/expiry.
  always_comb begin
    state_d   = state_q;
    snz_cnt_d = snz_cnt_q;
    if (!enable_q) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_ARMED;
        ST_ARMED:    if (fire) state_d = ST_RINGING;
        ST_RINGING: begin
          if (stop_cmd) begin
            state_d = ST_ARMED;
          end else if (snooze_cmd) begin
            state_d   = ST_SNOOZE;
            snz_cnt_d = SNZ_LOAD;
          end else if (ring_done) begin
            state_d = ST_ARMED;
          end
        end
        ST_SNOOZE: begin
          if (stop_cmd) begin
            state_d = ST_ARMED;
          end else if (min_tick) begin
            snz_cnt_d = snz_cnt_q - SNZ_ONE;
            if (snz_cnt_q == SNZ_ONE) state_d = ST_RINGING;
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  // All state of the block, including the edge detectors and start-up flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_h_q <= '0;
      alarm_m_q <= '0;
      enable_q  <= 1'b0;
      state_q   <= ST_DISABLED;
      snz_cnt_q <= '0;
      match_q   <= 1'b0;
      min0_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      alarm_h_q <= alarm_h_d;
      alarm_m_q <= alarm_m_d;
      enable_q  <= enable_d;
      state_q   <= state_d;
      snz_cnt_q <= snz_cnt_d;
      match_q   <= match;
      min0_q    <= min0;
      valid_q   <= 1'b1;
    end
  end

  // CPU read mux; reads as zero when not selected.
  always_comb begin
    data_out = 6'd0;
    if (sel) begin
      case (address)
        ADDR_ALARM_H: data_out = {1'b0, alarm_h_q};
        ADDR_ALARM_M: data_out = alarm_m_q;
        ADDR_CTRL:    data_out = {5'b0, enable_q};
        ADDR_STATUS:  data_out = {3'b0, (state_q == ST_SNOOZE), state_q};
        default:      data_out = 6'd0;
      endcase
    end
  end

  alarm_prescaler #(
    .CLK_PER_SEC (CLK_PER_SEC),
    .RING_SEC    (RING_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (ring_start),
    .en   (ringing),
    .done (ring_done)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: register table, hand-written ring/snooze/stop
// sequences and a randomized run, all checked every cycle against an
// event-level model of the alarm.
module tb_alarm_ctrl;

  localparam int CPS  = 4;
  localparam int RSEC = 3;
  localparam int SNZ  = 2;
  localparam int RING_CYCLES = CPS * RSEC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hour1 = '0;
  logic [3:0] hour0 = '0;
  logic [2:0] min1 = '0;
  logic [3:0] min0 = '0;
  logic       sel = 1'b0;
  logic [1:0] address = '0;
  logic       write_en = 1'b0;
  logic [5:0] data_in = '0;
  logic [5:0] data_out;
  logic       ring;

  int total = 0;
  int bad = 0;

  alarm_ctrl #(
    .CLK_PER_SEC (CPS),
    .RING_SEC    (RSEC),
    .SNOOZE_MIN  (SNZ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hour1    (hour1),
    .hour0    (hour0),
    .min1     (min1),
    .min0     (min0),
    .sel      (sel),
    .address  (address),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .ring     (ring)
  );

  always #5 clk = ~clk;

  // Event-level model. Phase numbers follow the STATUS encoding:
  // 0 off, 1 waiting for alarm time, 2 sounding, 3 snoozing.
  int m_ah, m_am, m_en, m_phase, m_snz_left, m_ring_age;
  int m_prev_match, m_prev_min0, m_started;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs now driven.
  task automatic model_step();
    int now_min, alarm_min, nxt;
    bit wr, stop, snooze, at_alarm, fire, tick;
    if (rst) begin
      m_ah = 0; m_am = 0; m_en = 0; m_phase = 0; m_snz_left = 0; m_ring_age = 0;
      m_prev_match = 0; m_prev_min0 = 0; m_started = 0;
      return;
    end
    now_min   = (int'(hour1) * 10 + int'(hour0)) * 60 + int'(min1) * 10 + int'(min0);
    alarm_min = m_ah * 60 + m_am;
    at_alarm  = (now_min == alarm_min);
    fire      = m_started != 0 && at_alarm && m_prev_match == 0;
    tick      = m_started != 0 && int'(min0) != m_prev_min0;
    wr        = sel && write_en;
    stop      = wr && address == 2'd2 && data_in[2];
    snooze    = wr && address == 2'd2 && data_in[1];
    nxt = m_phase;
    if (m_en == 0) nxt = 0;
    else if (m_phase == 0) nxt = 1;
    else if (m_phase == 1 && fire) nxt = 2;
    else if (m_phase == 2) begin
      if (stop) nxt = 1;
      else if (snooze) begin nxt = 3; m_snz_left = SNZ; end
      else if (m_ring_age + 1 == RING_CYCLES) nxt = 1;
    end else if (m_phase == 3) begin
      if (stop) nxt = 1;
      else if (tick) begin
        m_snz_left--;
        if (m_snz_left == 0) nxt = 2;
      end
    end
    m_ring_age = (nxt == 2 && m_phase != 2) ? 0 : m_ring_age + 1;
    m_phase = nxt;
    if (wr) begin
      if (address == 2'd0 && data_in <= 6'd23) m_ah = int'(data_in);
      if (address == 2'd1 && data_in <= 6'd59) m_am = int'(data_in);
      if (address == 2'd2) m_en = int'(data_in[0]);
    end
    m_prev_match = int'(at_alarm);
    m_prev_min0  = int'(min0);
    m_started    = 1;
  endtask

  function automatic int model_dout();
    if (!sel) return 0;
    case (address)
      2'd0: return m_ah;
      2'd1: return m_am;
      2'd2: return m_en;
      default: return (m_phase == 3 ? 4 : 0) + m_phase;
    endcase
  endfunction

  // One clock with model comparison just after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("ring_model", int'(ring), int'(m_phase == 2));
    check("dout_model", int'(data_out), model_dout());
  endtask

  task automatic wr(input int a, input int d);
    sel = 1'b1; write_en = 1'b1; address = 2'(a); data_in = 6'(d);
    $display("write addr=%0d data=%0d", a, d);
    cycle();
    write_en = 1'b0;
  endtask

  task automatic rd(input string name, input int a, input int want);
    sel = 1'b1; write_en = 1'b0; address = 2'(a);
    cycle();
    check(name, int'(data_out), want);
  endtask

  task automatic settime(input int h, input int m);
    hour1 = 2'(h / 10); hour0 = 4'(h % 10);
    min1  = 3'(m / 10); min0  = 4'(m % 10);
  endtask

  typedef struct {
    int addr;
    int wdata;
    int rd_exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r;
    int c;
    int t;
    vecs[0]  = '{0, 7, 7};
    vecs[1]  = '{0, 24, 7};
    vecs[2]  = '{1, 30, 30};
    vecs[3]  = '{1, 60, 30};
    vecs[4]  = '{0, 23, 23};
    vecs[5]  = '{1, 59, 59};
    vecs[6]  = '{0, 7, 7};
    vecs[7]  = '{1, 30, 30};
    vecs[8]  = '{2, 1, 1};
    vecs[9]  = '{2, 8, 0};
    vecs[10] = '{2, 1, 1};

    // Reset state.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_ring", int'(ring), 0);
    check("reset_dout_unsel", int'(data_out), 0);
    rd("reset_alarm_h", 0, 0);
    rd("reset_alarm_m", 1, 0);
    rd("reset_ctrl", 2, 0);
    rd("reset_status", 3, 0);

    // Register table: write then read back.
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd("table_readback", vecs[i].addr, vecs[i].rd_exp);
    end

    // Alarm 07:30 rings one edge after match and lasts 12 cycles.
    settime(7, 29); cycle(); cycle();
    settime(7, 30); cycle();
    check("ring_rise", int'(ring), 1);
    rd("status_ringing", 3, 2);
    n = 1;
    while (ring === 1'b1 && n < 30) begin cycle(); n++; end
    check("ring_length", n, RING_CYCLES);
    rd("status_after_timeout", 3, 1);

    // Snooze, then the second minute change re-rings.
    settime(7, 29); cycle();
    settime(7, 30); cycle();
    check("ring_before_snooze", int'(ring), 1);
    wr(2, 3);
    check("ring_after_snooze", int'(ring), 0);
    rd("status_snooze", 3, 7);
    settime(7, 31); cycle();
    check("snooze_tick1", int'(ring), 0);
    settime(7, 32); cycle();
    check("snooze_tick2", int'(ring), 1);

    // Stop, wrap through midnight, ring again; enabling at 07:30 is quiet.
    wr(2, 5);
    check("ring_after_stop", int'(ring), 0);
    rd("status_after_stop", 3, 1);
    settime(7, 33); cycle();
    settime(23, 59); cycle();
    settime(0, 0); cycle();
    settime(7, 29); cycle();
    settime(7, 30); cycle();
    check("ring_next_day", int'(ring), 1);
    wr(2, 5);
    wr(2, 0);
    wr(2, 1);
    cycle(); cycle(); cycle();
    check("enable_in_minute_quiet", int'(ring), 0);

    // Disable while ringing.
    settime(7, 29); cycle();
    settime(7, 30); cycle();
    check("ring_before_disable", int'(ring), 1);
    wr(2, 0);
    cycle();
    check("ring_after_disable", int'(ring), 0);
    rd("status_disabled", 3, 0);

    // Reset while snoozing.
    wr(2, 1);
    settime(7, 29); cycle();
    settime(7, 30); cycle();
    wr(2, 3);
    rd("status_snooze2", 3, 7);
    rst = 1'b1;
    settime(0, 0);
    cycle();
    rst = 1'b0;
    check("ring_post_reset", int'(ring), 0);
    rd("post_reset_alarm_h", 0, 0);
    rd("post_reset_alarm_m", 1, 0);
    rd("post_reset_ctrl", 2, 0);
    rd("post_reset_status", 3, 0);
    wr(2, 1);
    cycle(); cycle(); cycle();
    check("no_fire_after_reset", int'(ring), 0);

    // Midnight alarm, then stop and snooze together: stop wins.
    settime(23, 59); cycle();
    settime(0, 0); cycle();
    check("ring_midnight", int'(ring), 1);
    wr(2, 7);
    check("ring_stop_and_snooze", int'(ring), 0);
    rd("status_stop_wins", 3, 1);

    // Randomized run against the model.
    wr(0, 7);
    wr(1, 30);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      rst = ($urandom_range(0, 299) == 0);
      sel = 1'($urandom_range(0, 1));
      address = 2'($urandom_range(0, 3));
      write_en = 1'b0;
      data_in = 6'($urandom);
      if (r < 8) begin
        sel = 1'b1;
        write_en = 1'b1;
        if (address == 2'd2 && $urandom_range(0, 4) != 0) data_in[0] = 1'b1;
        $display("write addr=%0d data=%0d", address, data_in);
      end else if (r < 22) begin
        c = $urandom_range(0, 2);
        if (c == 0) t = m_ah * 60 + m_am;
        else if (c == 1) t = (m_ah * 60 + m_am + 1439) % 1440;
        else t = $urandom_range(0, 1439);
        settime(t / 60, t % 60);
      end
      cycle();
    end
    rst = 1'b0;
    write_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

CPU-configured alarm scheduler sitting beside the time-of-day `timer`. It watches `timer`'s BCD display digits and compares them with a programmed alarm time. It sequences the alarm through armed, ringing and snooze phases and drives a `ring` level to the buzzer/LED logic. It exposes a 4-register CPU window with the same `sel`/`write_en`/`data_in`/`data_out` handshake as `timer`.

## Interface
- `CLK_PER_SEC`, 50000000: clocks per second (20 ns clock).
- `RING_SEC`, 60: ring duration in seconds before auto-stop; must be ≥1.
- `SNOOZE_MIN`, 5: snooze length in displayed-minute changes; must be ≥1.

- `clk` in 1: single clock. Reset is synchronous and active-high: `rst` in 1.
- `hour1` in 2, `hour0` in 4, `min1` in 3, `min0` in 4: current time in BCD, taken from `timer`.
- `sel` in 1: CPU select.
- `address` in 2: register index. 0 ALARM_H, 1 ALARM_M, 2 CTRL, 3 STATUS.
- `write_en` in 1: write strobe, qualified by `sel`.
- `data_in` in 6: write data.
- `data_out` out 6: read data.
- `ring` out 1: alarm sounding.

## Operation
- Current time is converted combinationally to binary: `h = hour1*10 + hour0` (5 b) and `m = min1*10 + min0` (6 b).
- Registers:
  - ALARM_H holds binary hours 0–23. A write of a value >23 is ignored.
  - ALARM_M holds binary minutes 0–59. A write of a value >59 is ignored.
  - CTRL write:
    - bit0 = enable (stored).
    - bit1 = snooze command (pulse, not stored).
    - bit2 = stop command (pulse, not stored).
  - CTRL read returns `{5'b0, enable}`.
  - STATUS is read-only: `{3'b0, snooze_active, state[1:0]}`.
- `data_out` is a combinational mux of the addressed register when `sel`=1, and 0 otherwise.
- `match` = (h == ALARM_H) && (m == ALARM_M). `match_q` is its registered copy.
- `fire` = match && !match_q, i.e. a rising edge of `match`. Enabling during the matching minute does not ring until the next day.
- `min_tick` = `min0` differs from its registered copy. A `valid` flag is cleared by reset and set one cycle later; `fire` and `min_tick` are suppressed while `valid`=0.
- State machine. Encodings: DISABLED=0, ARMED=1, RINGING=2, SNOOZE=3.
  - DISABLED: enable=1 → ARMED.
  - ARMED: `fire` → RINGING.
  - RINGING: `ring`=1. Events by priority:
    - stop → ARMED.
    - snooze → SNOOZE, with `snz_cnt` ← SNOOZE_MIN.
    - `sec_cnt` reaches RING_SEC → ARMED.
  - SNOOZE: stop → ARMED. Each `min_tick` decrements `snz_cnt`. A `min_tick` seen with `snz_cnt`==1 → RINGING.
  - Global priority within a cycle: enable=0 (→ DISABLED) > stop > snooze > ring timeout > `fire` / snooze expiry.
- Commands (snooze, stop) issued in states where they do not apply are ignored.
- Prescaler `pre_cnt` counts 0..CLK_PER_SEC-1 and wraps. Each wrap increments `sec_cnt`.
  - Both counters clear on every entry to RINGING, so ringing lasts exactly RING_SEC*CLK_PER_SEC cycles.
  - Both counters are frozen outside RINGING.
- `ring` is decoded from the state (state==RINGING).

## Timing
- Reset values:
  - state DISABLED, `ring`=0.
  - ALARM_H=0, ALARM_M=0, enable=0.
  - `snz_cnt`=0, `pre_cnt`=0, `sec_cnt`=0.
  - `match_q`=0, `valid`=0.
  - `data_out`=0 (since `sel`=0).
- Reset mid-ring returns the block to DISABLED with `ring`=0 on the next cycle.
- A write sampled at edge N is visible on `data_out` and in the state machine from cycle N+1.
- If time inputs change at edge N and make `match` true, `fire` is evaluated at edge N+1 and `ring`=1 from that edge.
- Stop or snooze written at edge N deasserts `ring` from edge N.
- Ring timeout: `ring` falls exactly RING_SEC*CLK_PER_SEC cycles after it rose.
- Snooze expiry: `ring` rises at the edge that samples the SNOOZE_MIN-th `min_tick`.
- Midnight wrap (23:59→00:00) needs no special handling. An alarm at 00:00 fires on the wrap.

## Structure
- Shared include `alarm_defs.vh`, used alongside `xdefs.vh`. It holds:
  - state encodings;
  - register addresses;
  - CTRL bit positions.
- One sub-module, `alarm_prescaler`: `pre_cnt`/`sec_cnt` with clear and enable inputs and a `done` output at RING_SEC.

## Test plan
All scenarios use CLK_PER_SEC=4, RING_SEC=3, SNOOZE_MIN=2.
- Write ALARM_H=7, ALARM_M=30, CTRL=1, then drive time 07:29→07:30 → `ring`=1 one edge later, and `ring`=0 exactly 12 cycles after rising. STATUS reads 1.
- Writes of ALARM_H=24 and ALARM_M=60 → reading back still returns the previous values.
- Ringing, then write CTRL=3 (snooze) → `ring` drops and STATUS=`6'b000111`. Two `min0` changes → `ring` rises at the second one.
- Ringing, then write CTRL=5 (stop) → ARMED. A later 07:30 after wrapping through 00:00 rings again. Time already at 07:30 when enable is written → no ring.
- Ringing, then write CTRL=0 → DISABLED with `ring`=0. Assert `rst` while in SNOOZE → all registers 0, and no `fire` on the first post-reset cycle even if the time equals 00:00.
- Alarm 00:00, time 23:59→00:00 → ring. Stop and snooze written in the same cycle → stop wins.
